// File: rtl/pc_pkg.sv
// Shared definitions for the fetch/PC unit: next-PC select codes and fetch state encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pc_pkg;

   // Next-PC select codes produced by the PC-control logic
   localparam logic [1:0] PC_HOLD   = 2'b00;
   localparam logic [1:0] PC_BRANCH = 2'b01;
   localparam logic [1:0] PC_JUMP   = 2'b10;
   localparam logic [1:0] PC_NEXT   = 2'b11;

   // Fetch sequencer states
   typedef enum logic [1:0] {
      ST_FETCH   = 2'd0,
      ST_HOLD    = 2'd1,
      ST_RESOLVE = 2'd2,
      ST_HALT    = 2'd3
   } fetch_state_t;

endpackage

// File: rtl/pc_next_mux.sv
// Combinational next-PC select from the current PC, the two targets and pc_src.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when next_pc is used.
//
// Ports:
//   pc, branch_target, jump_target : candidate addresses
//   pc_src                         : select code (pc_pkg PC_* values)
//   next_pc                        : selected address
//   pc_inc                         : pc+1, wrapping; also used for resume and link
module pc_next_mux
   import pc_pkg::*;
#(
   parameter int PC_W = 32
) (
   input  logic [PC_W-1:0] pc,
   input  logic [PC_W-1:0] branch_target,
   input  logic [PC_W-1:0] jump_target,
   input  logic [1:0]      pc_src,
   output logic [PC_W-1:0] next_pc,
   output logic [PC_W-1:0] pc_inc
);

   localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

   // Word-addressed: sequential step is +1; the carry out is dropped so all-ones wraps to 0
   assign pc_inc = pc + PC_ONE;

   always_comb begin
      next_pc = pc;
      case (pc_src)
         PC_HOLD:   next_pc = pc;
         PC_BRANCH: next_pc = branch_target;
         PC_JUMP:   next_pc = jump_target;
         PC_NEXT:   next_pc = pc_inc;
         default:   next_pc = pc;
      endcase
   end

endmodule

// File: rtl/fetch_pc_unit.sv
// PC register and fetch sequencer: FETCH -> HOLD -> RESOLVE -> (FETCH | HALT).
// Latency: ack in N gives instr_valid in N+1; pc_src_valid in M gives imem_req with new address in M+1.
// Backpressure: holds the instruction until instr_ready; holds the request until imem_ack.
//
// Optional feature macro: PC_LINK_EN (adds is_jal input and link_addr/link_we outputs).
//
// Ports:
//   clk, rst_n                      : clock, synchronous active-low reset
//   pc_src, pc_src_valid            : next-PC decision strobe, honoured only in RESOLVE
//   branch_target, jump_target      : targets, sampled with pc_src_valid
//   resume                          : leave HALT (pc advances by one)
//   imem_req/imem_addr/imem_ack/imem_rdata : instruction memory handshake
//   instr_valid/instr_ready/instr/pc_out   : held instruction to decode
//   halted                          : unit is in HALT
//   is_jal, link_addr, link_we      : (PC_LINK_EN) return-address write for jump-and-link
module fetch_pc_unit
   import pc_pkg::*;
#(
   parameter int              PC_W     = 32,
   parameter logic [PC_W-1:0] RESET_PC = '0,
   parameter int              INSTR_W  = 32
) (
   input  logic               clk,
   input  logic               rst_n,
`ifdef PC_LINK_EN
   input  logic               is_jal,
   output logic [PC_W-1:0]    link_addr,
   output logic               link_we,
`endif
   input  logic [1:0]         pc_src,
   input  logic               pc_src_valid,
   input  logic [PC_W-1:0]    branch_target,
   input  logic [PC_W-1:0]    jump_target,
   input  logic               resume,
   output logic               imem_req,
   output logic [PC_W-1:0]    imem_addr,
   input  logic               imem_ack,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic               instr_valid,
   input  logic               instr_ready,
   output logic [INSTR_W-1:0] instr,
   output logic [PC_W-1:0]    pc_out,
   output logic               halted
);

   fetch_state_t    state;
   logic [PC_W-1:0] pc;
   logic [PC_W-1:0] next_pc;
   logic [PC_W-1:0] pc_inc;

   // Fetch address comes straight from the PC register
   assign imem_addr = pc;

   pc_next_mux #(
      .PC_W (PC_W)
   ) u_next_mux (
      .pc            (pc),
      .branch_target (branch_target),
      .jump_target   (jump_target),
      .pc_src        (pc_src),
      .next_pc       (next_pc),
      .pc_inc        (pc_inc)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= ST_FETCH;
         pc          <= RESET_PC;
         instr       <= '0;
         pc_out      <= '0;
         instr_valid <= 1'b0;
         imem_req    <= 1'b0;
         halted      <= 1'b0;
`ifdef PC_LINK_EN
         link_addr   <= '0;
         link_we     <= 1'b0;
`else
         // no link register in this build
`endif
      end else begin
`ifdef PC_LINK_EN
         // single-cycle pulse unless re-armed below
         link_we <= 1'b0;
`endif
         case (state)
            ST_FETCH: begin
               // Entering FETCH straight out of reset the request is still low;
               // raise it first, and only accept an ack against a live request.
               if (!imem_req) begin
                  imem_req <= 1'b1;
               end else if (imem_ack) begin
                  instr       <= imem_rdata;
                  pc_out      <= pc;
                  instr_valid <= 1'b1;
                  imem_req    <= 1'b0;
                  state       <= ST_HOLD;
               end
            end

            ST_HOLD: begin
               if (instr_ready) begin
                  instr_valid <= 1'b0;
                  state       <= ST_RESOLVE;
               end
            end

            ST_RESOLVE: begin
               if (pc_src_valid) begin
                  pc <= next_pc;
                  if (pc_src == PC_HOLD) begin
                     halted <= 1'b1;
                     state  <= ST_HALT;
                  end else begin
                     // request goes out with the new address the very next cycle
                     imem_req <= 1'b1;
                     state    <= ST_FETCH;
                  end
`ifdef PC_LINK_EN
                  if (pc_src == PC_JUMP && is_jal) begin
                     link_addr <= pc_inc;
                     link_we   <= 1'b1;
                  end
`endif
               end
            end

            ST_HALT: begin
               if (resume) begin
                  pc       <= pc_inc;
                  halted   <= 1'b0;
                  imem_req <= 1'b1;
                  state    <= ST_FETCH;
               end
            end

            default: begin
               state <= ST_FETCH;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: a per-cycle vector table plus hand sequences.
// Latency: n/a.
// Backpressure: n/a.
module tb_fetch_pc_unit;

   logic        clk;
   logic        rst_n;
   logic [1:0]  pc_src;
   logic        pc_src_valid;
   logic [31:0] branch_target;
   logic [31:0] jump_target;
   logic        resume;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] pc_out;
   logic        halted;
`ifdef PC_LINK_EN
   logic        is_jal;
   logic [31:0] link_addr;
   logic        link_we;
`endif

   int n_vec  = 0;
   int n_miss = 0;

   fetch_pc_unit #(
      .PC_W     (32),
      .RESET_PC (32'h0),
      .INSTR_W  (32)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
`ifdef PC_LINK_EN
      .is_jal        (is_jal),
      .link_addr     (link_addr),
      .link_we       (link_we),
`endif
      .pc_src        (pc_src),
      .pc_src_valid  (pc_src_valid),
      .branch_target (branch_target),
      .jump_target   (jump_target),
      .resume        (resume),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ack      (imem_ack),
      .imem_rdata    (imem_rdata),
      .instr_valid   (instr_valid),
      .instr_ready   (instr_ready),
      .instr         (instr),
      .pc_out        (pc_out),
      .halted        (halted)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // One record = inputs held for one cycle + outputs expected just after that edge
   typedef struct {
      logic        rst_n;
      logic [1:0]  src;
      logic        srcv;
      logic [31:0] bt;
      logic [31:0] jt;
      logic        res;
      logic        ack;
      logic [31:0] rdata;
      logic        rdy;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_vld;
      logic [31:0] e_instr;
      logic [31:0] e_pcout;
      logic        e_halt;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(
      logic rst, logic [1:0] src, logic srcv, logic [31:0] bt, logic [31:0] jt,
      logic res, logic ack, logic [31:0] rdata, logic rdy,
      logic e_req, logic [31:0] e_addr, logic e_vld, logic [31:0] e_instr,
      logic [31:0] e_pcout, logic e_halt);
      vec_t v;
      v.rst_n = rst;   v.src = src;     v.srcv = srcv;   v.bt = bt;     v.jt = jt;
      v.res = res;     v.ack = ack;     v.rdata = rdata; v.rdy = rdy;
      v.e_req = e_req; v.e_addr = e_addr; v.e_vld = e_vld;
      v.e_instr = e_instr; v.e_pcout = e_pcout; v.e_halt = e_halt;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic idle();
      rst_n = 1'b1; pc_src = 2'b00; pc_src_valid = 1'b0; branch_target = '0;
      jump_target = '0; resume = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
      instr_ready = 1'b0;
`ifdef PC_LINK_EN
      is_jal = 1'b0;
`endif
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      idle();
      rst_n = 1'b0;

      //            rst src v  bt         jt          res ack rdata        rdy | req addr         vld instr        pcout        halt
      tbl.push_back(mk(0, 0, 0, 0,        0,           0, 0, 0,            0,   0, 0,           0, 0,           0,           0));
      tbl.push_back(mk(1, 0, 0, 0,        0,           0, 0, 0,            0,   1, 0,           0, 0,           0,           0));
      tbl.push_back(mk(1, 0, 0, 0,        0,           0, 0, 0,            0,   1, 0,           0, 0,           0,           0));
      // wait cycle with stray srcv/resume/ready in FETCH
      tbl.push_back(mk(1, 1, 1, 32'h999,  0,           1, 0, 0,            1,   1, 0,           0, 0,           0,           0));
      tbl.push_back(mk(1, 0, 0, 0,        0,           0, 1, 32'hA5A50001, 0,   0, 0,           1, 32'hA5A50001, 0,          0));
      // stray ack/srcv in HOLD
      tbl.push_back(mk(1, 1, 1, 32'h999,  0,           0, 1, 32'hDEAD,     0,   0, 0,           1, 32'hA5A50001, 0,          0));
      tbl.push_back(mk(1, 0, 0, 0,        0,           0, 0, 0,            1,   0, 0,           0, 32'hA5A50001, 0,          0));
      tbl.push_back(mk(1, 3, 1, 0,        0,           0, 0, 0,            0,   1, 1,           0, 32'hA5A50001, 0,          0));
      tbl.push_back(mk(1, 0, 0, 0,        0,           0, 1, 32'h1111,     0,   0, 1,           1, 32'h1111,    1,           0));
      // srcv together with the ready handshake is ignored
      tbl.push_back(mk(1, 2, 1, 0,        32'h555,     0, 0, 0,            1,   0, 1,           0, 32'h1111,    1,           0));
      tbl.push_back(mk(1, 3, 1, 0,        0,           0, 0, 0,            0,   1, 2,           0, 32'h1111,    1,           0));
      tbl.push_back(mk(1, 0, 0, 0,        0,           0, 1, 32'h2222,     0,   0, 2,           1, 32'h2222,    2,           0));
      tbl.push_back(mk(1, 0, 0, 0,        0,           0, 0, 0,            1,   0, 2,           0, 32'h2222,    2,           0));
      tbl.push_back(mk(1, 3, 1, 0,        0,           0, 0, 0,            0,   1, 3,           0, 32'h2222,    2,           0));
      tbl.push_back(mk(1, 0, 0, 0,        0,           0, 1, 32'h3333,     0,   0, 3,           1, 32'h3333,    3,           0));
      tbl.push_back(mk(1, 0, 0, 0,        0,           0, 0, 0,            1,   0, 3,           0, 32'h3333,    3,           0));
      tbl.push_back(mk(1, 2, 1, 0,        5,           0, 0, 0,            0,   1, 5,           0, 32'h3333,    3,           0));
      tbl.push_back(mk(1, 0, 0, 0,        0,           0, 1, 32'h5555,     0,   0, 5,           1, 32'h5555,    5,           0));
      tbl.push_back(mk(1, 0, 0, 0,        0,           0, 0, 0,            1,   0, 5,           0, 32'h5555,    5,           0));
      tbl.push_back(mk(1, 1, 1, 32'h40,   32'h77,      0, 0, 0,            0,   1, 32'h40,      0, 32'h5555,    5,           0));
      tbl.push_back(mk(1, 0, 0, 0,        0,           0, 1, 32'h4040,     0,   0, 32'h40,      1, 32'h4040,    32'h40,      0));
      tbl.push_back(mk(1, 0, 0, 0,        0,           0, 0, 0,            1,   0, 32'h40,      0, 32'h4040,    32'h40,      0));
      tbl.push_back(mk(1, 2, 1, 32'h88,   32'h100,     0, 0, 0,            0,   1, 32'h100,     0, 32'h4040,    32'h40,      0));
      tbl.push_back(mk(1, 0, 0, 0,        0,           0, 1, 32'h100,      0,   0, 32'h100,     1, 32'h100,     32'h100,     0));
      tbl.push_back(mk(1, 0, 0, 0,        0,           0, 0, 0,            1,   0, 32'h100,     0, 32'h100,     32'h100,     0));
      tbl.push_back(mk(1, 2, 1, 0,        7,           0, 0, 0,            0,   1, 7,           0, 32'h100,     32'h100,     0));
      tbl.push_back(mk(1, 0, 0, 0,        0,           0, 1, 32'h7777,     0,   0, 7,           1, 32'h7777,    7,           0));
      tbl.push_back(mk(1, 0, 0, 0,        0,           0, 0, 0,            1,   0, 7,           0, 32'h7777,    7,           0));
      // stop at pc=7
      tbl.push_back(mk(1, 0, 1, 0,        0,           0, 0, 0,            0,   0, 7,           0, 32'h7777,    7,           1));
      // parked in HALT for 10 cycles with stray srcv/ack/ready
      for (int i = 0; i < 10; i++)
         tbl.push_back(mk(1, 3, 1, 32'h999, 32'h999,  0, 1, 32'hBAD,      1,   0, 7,           0, 32'h7777,    7,           1));
      tbl.push_back(mk(1, 0, 0, 0,        0,           1, 0, 0,            0,   1, 8,           0, 32'h7777,    7,           0));
      tbl.push_back(mk(1, 0, 0, 0,        0,           0, 1, 32'h8888,     0,   0, 8,           1, 32'h8888,    8,           0));
      tbl.push_back(mk(1, 0, 0, 0,        0,           0, 0, 0,            1,   0, 8,           0, 32'h8888,    8,           0));
      // wrap at all-ones
      tbl.push_back(mk(1, 2, 1, 0,        32'hFFFFFFFF, 0, 0, 0,           0,   1, 32'hFFFFFFFF, 0, 32'h8888,   8,           0));
      tbl.push_back(mk(1, 0, 0, 0,        0,           0, 1, 32'hF0F0,     0,   0, 32'hFFFFFFFF, 1, 32'hF0F0,   32'hFFFFFFFF, 0));
      tbl.push_back(mk(1, 0, 0, 0,        0,           0, 0, 0,            1,   0, 32'hFFFFFFFF, 0, 32'hF0F0,   32'hFFFFFFFF, 0));
      tbl.push_back(mk(1, 3, 1, 0,        0,           0, 0, 0,            0,   1, 0,           0, 32'hF0F0,    32'hFFFFFFFF, 0));
      tbl.push_back(mk(1, 0, 0, 0,        0,           0, 1, 32'h1234,     0,   0, 0,           1, 32'h1234,    0,           0));
      tbl.push_back(mk(1, 0, 0, 0,        0,           0, 0, 0,            1,   0, 0,           0, 32'h1234,    0,           0));
      tbl.push_back(mk(1, 2, 1, 0,        32'h33,      0, 0, 0,            0,   1, 32'h33,      0, 32'h1234,    0,           0));
      // reset mid-fetch, then mid-hold
      tbl.push_back(mk(0, 0, 0, 0,        0,           0, 0, 0,            0,   0, 0,           0, 0,           0,           0));
      tbl.push_back(mk(1, 0, 0, 0,        0,           0, 0, 0,            0,   1, 0,           0, 0,           0,           0));
      tbl.push_back(mk(1, 0, 0, 0,        0,           0, 1, 32'hABCD,     0,   0, 0,           1, 32'hABCD,    0,           0));
      tbl.push_back(mk(0, 0, 0, 0,        0,           0, 0, 0,            0,   0, 0,           0, 0,           0,           0));
      tbl.push_back(mk(1, 0, 0, 0,        0,           0, 0, 0,            0,   1, 0,           0, 0,           0,           0));

      for (int i = 0; i < tbl.size(); i++) begin
         rst_n = tbl[i].rst_n;  pc_src = tbl[i].src;   pc_src_valid = tbl[i].srcv;
         branch_target = tbl[i].bt; jump_target = tbl[i].jt; resume = tbl[i].res;
         imem_ack = tbl[i].ack; imem_rdata = tbl[i].rdata; instr_ready = tbl[i].rdy;
         tick();
         chk($sformatf("v%0d.imem_req", i),    {31'b0, imem_req},    {31'b0, tbl[i].e_req});
         chk($sformatf("v%0d.imem_addr", i),   imem_addr,            tbl[i].e_addr);
         chk($sformatf("v%0d.instr_valid", i), {31'b0, instr_valid}, {31'b0, tbl[i].e_vld});
         chk($sformatf("v%0d.instr", i),       instr,                tbl[i].e_instr);
         chk($sformatf("v%0d.pc_out", i),      pc_out,               tbl[i].e_pcout);
         chk($sformatf("v%0d.halted", i),      {31'b0, halted},      {31'b0, tbl[i].e_halt});
      end

      // Best-case throughput: zero-wait ack, immediate ready, immediate PC+1
      for (int k = 0; k < 4; k++) begin
         idle(); imem_ack = 1'b1; imem_rdata = 32'hC000_0000 + k;
         tick();
         chk($sformatf("tp%0d.instr", k),  instr,  32'hC000_0000 + k);
         chk($sformatf("tp%0d.pc_out", k), pc_out, k);
         chk($sformatf("tp%0d.req_lo", k), {31'b0, imem_req}, 32'd0);
         idle(); instr_ready = 1'b1;
         tick();
         chk($sformatf("tp%0d.vld_lo", k), {31'b0, instr_valid}, 32'd0);
         idle(); pc_src_valid = 1'b1; pc_src = 2'b11;
         tick();
         chk($sformatf("tp%0d.req", k),  {31'b0, imem_req}, 32'd1);
         chk($sformatf("tp%0d.addr", k), imem_addr, k + 1);
      end

`ifdef PC_LINK_EN
      // pc=4 in FETCH: first move to 0x10 without link
      idle(); imem_ack = 1'b1; tick();
      idle(); instr_ready = 1'b1; tick();
      idle(); pc_src_valid = 1'b1; pc_src = 2'b10; jump_target = 32'h10; tick();
      chk("lk.addr10", imem_addr, 32'h10);
      chk("lk.we_nojal0", {31'b0, link_we}, 32'd0);
      // jal at pc=0x10
      idle(); imem_ack = 1'b1; tick();
      idle(); instr_ready = 1'b1; tick();
      idle(); pc_src_valid = 1'b1; pc_src = 2'b10; jump_target = 32'h80; is_jal = 1'b1; tick();
      chk("lk.we_pulse", {31'b0, link_we}, 32'd1);
      chk("lk.link_addr", link_addr, 32'h11);
      chk("lk.addr80", imem_addr, 32'h80);
      idle(); tick();
      chk("lk.we_drop", {31'b0, link_we}, 32'd0);
      // back to 0x10, then plain jump with is_jal=0
      idle(); imem_ack = 1'b1; tick();
      idle(); instr_ready = 1'b1; tick();
      idle(); pc_src_valid = 1'b1; pc_src = 2'b10; jump_target = 32'h10; tick();
      idle(); imem_ack = 1'b1; tick();
      idle(); instr_ready = 1'b1; tick();
      idle(); pc_src_valid = 1'b1; pc_src = 2'b10; jump_target = 32'h90; tick();
      chk("lk.we_nojal", {31'b0, link_we}, 32'd0);
      chk("lk.addr_held", link_addr, 32'h11);
      chk("lk.addr90", imem_addr, 32'h90);
      idle(); rst_n = 1'b0; tick();
      chk("lk.rst_addr", link_addr, 32'h0);
      chk("lk.rst_we", {31'b0, link_we}, 32'd0);
      idle(); tick();
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Program-counter register and instruction-fetch sequencer for the simple RISC core. It consumes the 2-bit PC-source selection produced by the PC-control logic, updates the PC, and fetches the next instruction word from instruction memory through a request/acknowledge handshake. It then holds that instruction for decode and waits for the next PC-source decision.

## Interface
- PC_W, 32, PC width; word-addressed, so the sequential increment is +1
- RESET_PC, 0, PC value loaded on reset
- INSTR_W, 32, instruction word width

- clk  in  1  single clock; all state updates on its rising edge
- rst_n  in  1  synchronous, active-low reset
- pc_src  in  2  next-PC select: 00 hold/stop, 01 branch target, 10 jump target, 11 PC+1
- pc_src_valid  in  1  one-cycle strobe; pc_src, branch_target and jump_target are valid
- branch_target  in  PC_W  taken-branch address
- jump_target  in  PC_W  jump address
- resume  in  1  one-cycle strobe; leave HALT
- imem_req  out  1  fetch request
- imem_addr  out  PC_W  fetch address; equals pc
- imem_ack  in  1  one-cycle strobe; imem_rdata valid
- imem_rdata  in  INSTR_W  fetched word
- instr_valid  out  1  instr/pc_out valid for decode
- instr_ready  in  1  decode accepts instr
- instr  out  INSTR_W  held instruction
- pc_out  out  PC_W  address of held instruction
- halted  out  1  unit is in HALT

## Operation
- States: FETCH, HOLD, RESOLVE, HALT.
- FETCH:
  - imem_req=1 and imem_addr=pc, both held stable until imem_ack.
  - On imem_ack: latch imem_rdata into instr, latch pc into pc_out, go to HOLD.
- HOLD:
  - instr_valid=1.
  - On instr_ready: go to RESOLVE.
- RESOLVE: wait for pc_src_valid, then act on pc_src:
  - 01: pc<=branch_target, go to FETCH.
  - 10: pc<=jump_target, go to FETCH.
  - 11: pc<=pc+1, modulo 2^PC_W (all-ones wraps to 0), go to FETCH.
  - 00: pc unchanged, go to HALT.
- HALT:
  - halted=1.
  - On resume: pc<=pc+1, go to FETCH.
- Ignored inputs:
  - pc_src_valid outside RESOLVE.
  - imem_ack outside FETCH.
  - instr_ready outside HOLD.
  - resume outside HALT.
- Target inputs are sampled only in the cycle pc_src_valid is high.

## Timing
- Reset (rst_n low at an edge):
  - pc=RESET_PC, state=FETCH.
  - instr=0, pc_out=0, instr_valid=0, imem_req=0, halted=0.
- imem_req first rises in the first cycle after rst_n is released.
- Reset mid-fetch or mid-hold: the transaction is abandoned, and imem_req/instr_valid drop at that edge.
- imem_ack in cycle N gives instr_valid=1 in cycle N+1.
- Zero-wait-state memory (ack in the first request cycle): minimum 1 cycle in FETCH.
- pc_src_valid in cycle M gives imem_req=1 with the new address in M+1.
- Best-case instruction throughput: 1 instruction per 3 cycles (FETCH, HOLD, RESOLVE, each 1 cycle).
- instr_ready arriving in the same cycle instr_valid rises is accepted: HOLD lasts 1 cycle.
- pc_src_valid coincident with the instr_ready handshake is ignored, because the unit is not yet in RESOLVE.
- All outputs are registered, except imem_addr, which is driven directly from pc.

## Configuration
- Macro: PC_LINK_EN.
- With PC_LINK_EN:
  - Adds input is_jal (1) and outputs link_addr (PC_W) and link_we (1).
  - In RESOLVE with pc_src_valid, pc_src=10 and is_jal=1: link_addr<=pc+1 (wraps), and link_we pulses for exactly one cycle (M+1).
  - Reset: link_addr=0, link_we=0.
- Without PC_LINK_EN: those ports and registers do not exist; behaviour is otherwise identical.

## Structure
- Shared package pc_pkg holds:
  - pc_src localparams: PC_HOLD=2'b00, PC_BRANCH=2'b01, PC_JUMP=2'b10, PC_NEXT=2'b11.
  - The fetch state encoding.
- One sub-module: pc_next_mux, a combinational next-PC select (pc, targets, pc_src → next_pc).

## Test plan
- Reset, then ack a fetch after 2 wait cycles with rdata=32'hA5A5_0001 → imem_addr=0; instr=32'hA5A5_0001 and pc_out=0 one cycle after ack; halted=0.
- Sequential flow: resolve with pc_src=11 three times → fetch addresses 0,1,2,3; pc_src_valid in cycle M gives imem_req with the new address in M+1.
- Branch/jump: pc=5, pc_src=01 with branch_target=0x40 → next fetch at 0x40; then pc_src=10 with jump_target=0x100 → next fetch at 0x100.
- Stop: pc_src=00 at pc=7 → halted=1 and imem_req=0 for 10 cycles; resume → fetch at 8.
- Boundaries:
  - pc=32'hFFFF_FFFF with pc_src=11 → fetch at 0.
  - Spurious imem_ack/pc_src_valid in the wrong state → no change.
  - rst_n low mid-FETCH → imem_req=0 next cycle and pc=RESET_PC.
- PC_LINK_EN: at pc=0x10, pc_src=10 with is_jal=1 and jump_target=0x80 → link_addr=0x11, link_we high for exactly 1 cycle, fetch at 0x80; the same with is_jal=0 → no link_we pulse.
